// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op codes, flag bit positions, FSM and slice
// select encodings, plus small op-classification helpers.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SBC = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_CP  = 4'd7;
  localparam logic [3:0] ALU_INC = 4'd8;
  localparam logic [3:0] ALU_DEC = 4'd9;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StFin
  } alu_state_e;

  typedef enum logic [1:0] {
    SelArith,
    SelAnd,
    SelXor,
    SelOr
  } slice_sel_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= ALU_DEC;
  endfunction

  function automatic logic op_is_logic(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_XOR) || (op == ALU_OR);
  endfunction

  // Ops whose H/C report borrow rather than carry, and which set N.
  function automatic logic op_is_borrow(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SBC) || (op == ALU_CP) || (op == ALU_DEC);
  endfunction

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit ALU slice: add with carry-in, or a bitwise logic op (carry-out forced 0).
module alu_nibble
  import alu_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  slice_sel_e i_sel,
  output logic [3:0] o_y,
  output logic       o_cout
);

  logic [4:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

  always_comb begin
    o_y    = w_sum[3:0];
    o_cout = w_sum[4];
    unique case (i_sel)
      SelAnd: begin
        o_y    = i_a & i_b;
        o_cout = 1'b0;
      end
      SelXor: begin
        o_y    = i_a ^ i_b;
        o_cout = 1'b0;
      end
      SelOr: begin
        o_y    = i_a | i_b;
        o_cout = 1'b0;
      end
      SelArith: ;
    endcase
  end

endmodule

// File: rtl/nibble_alu.sv
// 8-bit ALU that runs low then high nibble through one shared 4-bit slice (start/done handshake).
// NIBBLE_ALU_FAST_LOGIC_EN: logic and illegal ops skip the nibble passes and finish in one cycle.
module nibble_alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [3:0] flags_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] flags_out,
  output logic       write_a
);

  alu_state_e r_state, w_state_next, w_idle_next;

  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_flags_in;
  logic [3:0] r_lo;
  logic [3:0] r_hi;
  logic       r_nc;
  logic       r_bc;

  logic [7:0] r_result;
  logic [3:0] r_flags_out;
  logic       r_write_a;
  logic       r_done;

  logic [7:0] w_b_eff;
  logic       w_cin;
  slice_sel_e w_sel;
  logic       w_hi_sel;
  logic [3:0] w_slice_a;
  logic [3:0] w_slice_b;
  logic       w_slice_cin;
  logic [3:0] w_slice_y;
  logic       w_slice_cout;

  logic [7:0] w_byte;
  logic       w_borrow;
  logic [7:0] w_result;
  logic [3:0] w_flags;
  logic       w_write;
  logic       w_accept;

  assign w_accept = (r_state == StIdle) && start;
  assign w_borrow = op_is_borrow(r_op);

  // Second operand and carry-in as seen by the adder; subtraction is a + ~b + !borrow.
  always_comb begin
    w_b_eff = r_b;
    w_cin   = 1'b0;
    w_sel   = SelArith;
    case (r_op)
      ALU_ADC: w_cin = r_flags_in[FLAG_C];
      ALU_SUB, ALU_CP: begin
        w_b_eff = ~r_b;
        w_cin   = 1'b1;
      end
      ALU_SBC: begin
        w_b_eff = ~r_b;
        w_cin   = ~r_flags_in[FLAG_C];
      end
      ALU_AND: w_sel = SelAnd;
      ALU_XOR: w_sel = SelXor;
      ALU_OR:  w_sel = SelOr;
      ALU_INC: w_b_eff = 8'h01;
      ALU_DEC: begin
        w_b_eff = 8'hFE;
        w_cin   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hi_sel    = (r_state == StHi);
  assign w_slice_a   = w_hi_sel ? r_a[7:4] : r_a[3:0];
  assign w_slice_b   = w_hi_sel ? w_b_eff[7:4] : w_b_eff[3:0];
  assign w_slice_cin = w_hi_sel ? r_nc : w_cin;

  alu_nibble u_slice (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (w_slice_cin),
    .i_sel  (w_sel),
    .o_y    (w_slice_y),
    .o_cout (w_slice_cout)
  );

`ifdef NIBBLE_ALU_FAST_LOGIC_EN
  logic [7:0] w_logic_byte;

  assign w_idle_next = (op_is_logic(op) || !op_is_legal(op)) ? StFin : StLo;

  always_comb begin
    w_logic_byte = 8'h00;
    case (r_op)
      ALU_AND: w_logic_byte = r_a & r_b;
      ALU_XOR: w_logic_byte = r_a ^ r_b;
      ALU_OR:  w_logic_byte = r_a | r_b;
      default: ;
    endcase
  end

  // Logic ops never visit LO/HI here, so the nibble registers are stale for them.
  assign w_byte = op_is_logic(r_op) ? w_logic_byte : {r_hi, r_lo};
`else
  assign w_idle_next = StLo;
  assign w_byte      = {r_hi, r_lo};
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_next = w_idle_next;
      StLo:   w_state_next = StHi;
      StHi:   w_state_next = StFin;
      StFin:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= 4'h0;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_flags_in <= 4'h0;
    end else if (w_accept) begin
      r_op       <= op;
      r_a        <= a_in;
      r_b        <= b_in;
      r_flags_in <= flags_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo <= 4'h0;
      r_nc <= 1'b0;
      r_hi <= 4'h0;
      r_bc <= 1'b0;
    end else if (r_state == StLo) begin
      r_lo <= w_slice_y;
      r_nc <= w_slice_cout;
    end else if (r_state == StHi) begin
      r_hi <= w_slice_y;
      r_bc <= w_slice_cout;
    end
  end

  // Final result and flags; illegal ops pass A and F through untouched.
  always_comb begin
    w_result = r_a;
    w_flags  = r_flags_in;
    w_write  = 1'b0;
    if (op_is_legal(r_op)) begin
      w_result        = w_byte;
      w_write         = (r_op != ALU_CP);
      w_flags[FLAG_Z] = (w_byte == 8'h00);
      w_flags[FLAG_N] = w_borrow;
      case (r_op)
        ALU_AND: begin
          w_flags[FLAG_H] = 1'b1;
          w_flags[FLAG_C] = 1'b0;
        end
        ALU_XOR, ALU_OR: begin
          w_flags[FLAG_H] = 1'b0;
          w_flags[FLAG_C] = 1'b0;
        end
        ALU_INC, ALU_DEC: w_flags[FLAG_H] = r_nc ^ w_borrow;
        default: begin
          w_flags[FLAG_H] = r_nc ^ w_borrow;
          w_flags[FLAG_C] = r_bc ^ w_borrow;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= 8'h00;
      r_flags_out <= 4'h0;
      r_write_a   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == StFin);
      if (r_state == StFin) begin
        r_result    <= w_result;
        r_flags_out <= w_flags;
        r_write_a   <= w_write;
      end
    end
  end

  assign busy      = (r_state != StIdle);
  assign done      = r_done;
  assign result    = r_result;
  assign flags_out = r_flags_out;
  assign write_a   = r_write_a;

endmodule

// File: tb/tb_nibble_alu.sv
// Self-checking bench for nibble_alu: directed cases, handshake corner cases, random ops vs model.
module tb_nibble_alu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] op;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] flags_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags_out;
  logic       write_a;

  int total = 0;
  int bad   = 0;

  nibble_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags_out (flags_out),
    .write_a   (write_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] o);
`ifdef NIBBLE_ALU_FAST_LOGIC_EN
    if (o == 4'd4 || o == 4'd5 || o == 4'd6 || o > 4'd9) return 1;
`endif
    return 3;
  endfunction

  // Reference model from the arithmetic definitions of each op.
  task automatic model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, output logic [7:0] r, output logic [3:0] fo,
                       output logic w);
    int ia, ib, ic, s, h;
    logic cy, hc;
    ia = int'(a);
    ib = int'(b);
    ic = int'(f[0]);
    s  = 0;
    h  = 0;
    cy = 1'b0;
    hc = 1'b0;
    case (o)
      4'd0, 4'd1: begin
        if (o == 4'd0) ic = 0;
        s  = ia + ib + ic;
        h  = (ia % 16) + (ib % 16) + ic;
        cy = (s > 255);
        hc = (h > 15);
      end
      4'd2, 4'd3, 4'd7: begin
        if (o != 4'd3) ic = 0;
        s  = ia - ib - ic;
        h  = (ia % 16) - (ib % 16) - ic;
        cy = (s < 0);
        hc = (h < 0);
      end
      4'd4: begin s = ia & ib; hc = 1'b1; end
      4'd5: s = ia ^ ib;
      4'd6: s = ia | ib;
      4'd8: begin s = ia + 1; hc = ((ia % 16) == 15); cy = f[0]; end
      4'd9: begin s = ia - 1; hc = ((ia % 16) == 0);  cy = f[0]; end
      default: ;
    endcase
    if (o > 4'd9) begin
      r  = a;
      fo = f;
      w  = 1'b0;
    end else begin
      r  = s[7:0];
      fo = {(r == 8'h00), (o == 4'd2 || o == 4'd3 || o == 4'd7 || o == 4'd9), hc, cy};
      w  = (o != 4'd7);
    end
  endtask

  // Issue one op, optionally poke a second start one cycle later, and check the completion.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] f, input logic [7:0] er,
                        input logic [3:0] ef, input logic ew, input bit poke);
    int lat;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    a_in     = a;
    b_in     = b;
    flags_in = f;
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = 4'($urandom_range(0, 15));
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
    flags_in = 4'($urandom);
    check({tag, "_busy"}, int'(busy), 1);
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      op    = 4'd2;
      a_in  = 8'h11;
      b_in  = 8'h22;
    end
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end while (!done && lat < 8);
    check({tag, "_latency"}, lat, exp_latency(o));
    check({tag, "_result"}, int'(result), int'(er));
    check({tag, "_flags"}, int'(flags_out), int'(ef));
    check({tag, "_write_a"}, int'(write_a), int'(ew));
  endtask

  initial begin
    logic [7:0] mr;
    logic [3:0] mf;
    logic       mw;
    logic [3:0] ro;
    logic [7:0] ra, rb;
    logic [3:0] rf;
    int         extra;
    int         held;

    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 4'd0;
    a_in     = 8'h00;
    b_in     = 8'h00;
    flags_in = 4'h0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_flags", int'(flags_out), 0);
    check("rst_write_a", int'(write_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 4'd0, 8'h3A, 8'hC6, 4'b0000, 8'h00, 4'b1011, 1'b1, 1'b0);
    held = int'(result);
    @(posedge clk);
    #1;
    check("hold_done_low", int'(done), 0);
    check("hold_result", int'(result), held);

    run_op("add_poke", 4'd0, 8'h3A, 8'hC6, 4'b0000, 8'h00, 4'b1011, 1'b1, 1'b1);
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("poke_no_extra_done", extra, 0);

    run_op("sub", 4'd2, 8'h3E, 8'h3F, 4'b0000, 8'hFF, 4'b0111, 1'b1, 1'b0);

    // Abort an ADD while the high nibble is in flight.
    @(negedge clk);
    start    = 1'b1;
    op       = 4'd0;
    a_in     = 8'h12;
    b_in     = 8'h34;
    flags_in = 4'h0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_flags", int'(flags_out), 0);
    check("abort_write_a", int'(write_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("abort_no_done", extra, 0);

    run_op("adc", 4'd1, 8'hE1, 8'h0F, 4'b0001, 8'hF1, 4'b0010, 1'b1, 1'b0);
    run_op("inc", 4'd8, 8'hFF, 8'h5C, 4'b0001, 8'h00, 4'b1011, 1'b1, 1'b0);
    run_op("dec", 4'd9, 8'h10, 8'hA7, 4'b0000, 8'h0F, 4'b0110, 1'b1, 1'b0);
    run_op("cp", 4'd7, 8'h3C, 8'h40, 4'b0000, 8'hFC, 4'b0101, 1'b0, 1'b0);
    run_op("and", 4'd4, 8'h5A, 8'h3F, 4'b0000, 8'h1A, 4'b0010, 1'b1, 1'b0);
    run_op("illegal", 4'd12, 8'h77, 8'h99, 4'b1010, 8'h77, 4'b1010, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rf = 4'($urandom);
      model(ro, ra, rb, rf, mr, mf, mw);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rf, mr, mf, mw, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
